// File: rtl/snax_hwpe_mac_regs_pkg.sv
// snax_hwpe_mac_regs_pkg: register map, STATUS layout and sequencer states of the MAC job register file
package snax_hwpe_mac_regs_pkg;
  localparam int IDX_CTRL = 0;
  localparam int IDX_STATUS = 1;
  localparam int CFG_BASE = 2;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR = 2;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mac_regs_state_t;
endpackage

// File: rtl/snax_hwpe_mac_regs_if.sv
// snax_hwpe_mac_regs_if: 32-bit periph bus between the HWPE control bridge (master) and the register file (slave)
interface snax_hwpe_mac_regs_if #(
  parameter int IdWidth = 5
) ();
  logic req;
  logic gnt;
  logic [31:0] add;
  logic wen;
  logic [3:0] be;
  logic [31:0] data;
  logic [IdWidth-1:0] id;
  logic r_valid;
  logic [31:0] r_data;
  logic [IdWidth-1:0] r_id;
  modport master (output req, add, wen, be, data, id, input gnt, r_valid, r_data, r_id);
  modport slave (input req, add, wen, be, data, id, output gnt, r_valid, r_data, r_id);
endinterface

// File: rtl/snax_be_reg32.sv
// snax_be_reg32: 32-bit register with async active-low reset, write enable and per-byte enables
module snax_be_reg32 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_o <= '0;
    else if (we_i)
      for (int b = 0; b < 4; b++)
        if (be_i[b]) q_o[8*b +: 8] <= d_i[8*b +: 8];
endmodule

// File: rtl/snax_hwpe_mac_regs.sv
// snax_hwpe_mac_regs: MAC job register file with CTRL/STATUS and IDLE/RUN sequencer on the HWPE periph bus.
// SNAX_HWPE_MAC_REGS_SHADOW_EN adds a shadow CFG bank copied to cfg_o at job launch.
module snax_hwpe_mac_regs
  import snax_hwpe_mac_regs_pkg::*;
#(
  parameter int NumCfgRegs = 24,
  parameter int IdWidth = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  snax_hwpe_mac_regs_if.slave      periph,
  output logic [NumCfgRegs*32-1:0] cfg_o,
  output logic                     start_o,
  output logic                     busy_o,
  input  logic                     done_i
);
  mac_regs_state_t state;
  logic [29:0] idx;
  logic [31:0] rdata;
  logic [31:0] cfg_rd [NumCfgRegs];
  logic gnt, wr, rd, run, go, start_req, status_hit, cfg_hit, status_rd;
  logic cfg_wr_en, err_set, done_q, err_q, unused_add;
  assign idx = periph.add[31:2];
  assign unused_add = ^periph.add[1:0];
  // r_valid is high exactly while a read response is pending, so it doubles as rsp_pend
  assign gnt = periph.req & ~periph.r_valid & rst_ni;
  assign periph.gnt = gnt;
  assign wr = gnt & ~periph.wen;
  assign rd = gnt & periph.wen;
  assign run = state == RUN;
  assign busy_o = run;
  assign status_hit = idx == 30'(IDX_STATUS);
  assign cfg_hit = idx >= 30'(CFG_BASE) && idx < 30'(CFG_BASE + NumCfgRegs);
  assign start_req = wr & (idx == 30'(IDX_CTRL)) & periph.be[0] & periph.data[0];
  assign go = start_req & ~run;
  assign status_rd = rd & status_hit;
`ifdef SNAX_HWPE_MAC_REGS_SHADOW_EN
  assign cfg_wr_en = wr & cfg_hit;
  assign err_set = start_req & run;
`else
  assign cfg_wr_en = wr & cfg_hit & ~run;
  assign err_set = (start_req | (wr & cfg_hit)) & run;
`endif
  for (genvar i = 0; i < NumCfgRegs; i++) begin : g_cfg
    snax_be_reg32 u_bank (
      .clk_i, .rst_ni,
      .we_i(cfg_wr_en && idx == 30'(CFG_BASE + i)),
      .be_i(periph.be), .d_i(periph.data), .q_o(cfg_rd[i])
    );
`ifdef SNAX_HWPE_MAC_REGS_SHADOW_EN
    logic [31:0] act;
    snax_be_reg32 u_act (
      .clk_i, .rst_ni, .we_i(go), .be_i(4'hF), .d_i(cfg_rd[i]), .q_o(act)
    );
    assign cfg_o[32*i +: 32] = act;
`else
    assign cfg_o[32*i +: 32] = cfg_rd[i];
`endif
  end
  always_comb begin
    rdata = '0;
    rdata[STATUS_BUSY] = status_hit & run;
    rdata[STATUS_DONE] = status_hit & done_q;
    rdata[STATUS_ERR] = status_hit & err_q;
    for (int i = 0; i < NumCfgRegs; i++)
      if (idx == 30'(CFG_BASE + i)) rdata = cfg_rd[i];
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      periph.r_valid <= 1'b0;
      periph.r_data <= '0;
      periph.r_id <= '0;
      start_o <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      periph.r_valid <= rd;
      periph.r_data <= rd ? rdata : '0;
      if (rd) periph.r_id <= IdWidth'(periph.id);
      start_o <= go;
      state <= go ? RUN : done_i ? IDLE : state;
      done_q <= (done_i & run) | (done_q & ~status_rd & ~go);
      err_q <= err_set | (err_q & ~status_rd);
    end
endmodule

// File: tb/tb_snax_hwpe_mac_regs.sv
// tb_snax_hwpe_mac_regs: scoreboard bench with a register-map reference model and randomized bus traffic
module tb_snax_hwpe_mac_regs;
  localparam int NCFG = 24;
  typedef struct {logic [31:0] d; logic [4:0] id;} rsp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [NCFG*32-1:0] cfg_o;
  logic start_o, busy_o, done_i;
  snax_hwpe_mac_regs_if #(.IdWidth(5)) bus ();

  snax_hwpe_mac_regs #(.NumCfgRegs(NCFG), .IdWidth(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .periph(bus),
    .cfg_o(cfg_o), .start_o(start_o), .busy_o(busy_o), .done_i(done_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  rsp_t sb[$];
  rsp_t got;

  logic [31:0] m_bank [NCFG];
  logic [31:0] m_act [NCFG];
  bit m_run, m_done, m_err;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [NCFG*32-1:0] exp_cfg();
    logic [NCFG*32-1:0] v;
    for (int i = 0; i < NCFG; i++)
`ifdef SNAX_HWPE_MAC_REGS_SHADOW_EN
      v[32*i +: 32] = m_act[i];
`else
      v[32*i +: 32] = m_bank[i];
`endif
    return v;
  endfunction

  task automatic chk_cfg(input string n);
    logic [NCFG*32-1:0] e;
    e = exp_cfg();
    checks++;
    if (cfg_o !== e) begin
      errors++;
      for (int i = 0; i < NCFG; i++)
        if (cfg_o[32*i +: 32] !== e[32*i +: 32]) begin
          $display("FAIL %s word %0d: got %h expected %h", n, i, cfg_o[32*i +: 32], e[32*i +: 32]);
          break;
        end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) begin
      m_bank[i] = '0;
      m_act[i] = '0;
    end
    m_run = 0;
    m_done = 0;
    m_err = 0;
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'({2'b00, a[31:2]});
  endfunction

  function automatic logic [31:0] model_value(input logic [31:0] a);
    int w;
    w = word_of(a);
    if (w == 1) return {29'd0, m_err, m_done, m_run};
    if (w >= 2 && w < 2 + NCFG) return m_bank[w-2];
    return 32'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, output bit starts);
    int w;
    w = word_of(a);
    starts = 0;
    if (w == 0 && be[0] && d[0]) begin
      if (m_run) m_err = 1;
      else begin
        m_run = 1;
        m_done = 0;
        starts = 1;
        for (int i = 0; i < NCFG; i++) m_act[i] = m_bank[i];
      end
    end else if (w >= 2 && w < 2 + NCFG) begin
`ifndef SNAX_HWPE_MAC_REGS_SHADOW_EN
      if (m_run) begin
        m_err = 1;
        return;
      end
`endif
      for (int b = 0; b < 4; b++)
        if (be[b]) m_bank[w-2][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic wait_gnt(output bit ok, output int waited);
    waited = 0;
    #1;
    while (!bus.gnt && waited < 8) begin
      @(posedge clk_i); #2;
      waited++;
    end
    ok = bus.gnt;
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL gnt_timeout: got 0 expected 1 at %0t", $time);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bit ok, starts;
    int w;
    bus.req = 1; bus.wen = 0; bus.add = a; bus.be = be; bus.data = d; bus.id = 5'($urandom);
    wait_gnt(ok, w);
    bus.req = 0;
    if (!ok) return;
    chk("wr_gnt_latency", 32'(w), 32'd0);
    model_write(a, be, d, starts);
    chk("start_pulse", 32'(start_o), 32'(starts));
    chk("busy", 32'(busy_o), 32'(m_run));
    chk_cfg("cfg_after_write");
    @(posedge clk_i); #1;
    chk("start_width", 32'(start_o), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a);
    bit ok;
    int w;
    rsp_t e;
    e.id = 5'($urandom);
    e.d = model_value(a);
    bus.req = 1; bus.wen = 1; bus.add = a; bus.be = 4'($urandom); bus.data = $urandom; bus.id = e.id;
    wait_gnt(ok, w);
    if (!ok) begin
      bus.req = 0;
      return;
    end
    if (word_of(a) == 1) begin
      m_done = 0;
      m_err = 0;
    end
    sb.push_back(e);
    chk("rd_valid_latency", 32'(bus.r_valid), 32'd1);
    chk("rd_single_gnt", 32'(bus.gnt), 32'd0);
    @(posedge clk_i); #1;
    bus.req = 0;
    chk("rd_valid_width", 32'(bus.r_valid), 32'd0);
  endtask

  task automatic pulse_done();
    done_i = 1;
    @(posedge clk_i); #1;
    done_i = 0;
    if (m_run) begin
      m_run = 0;
      m_done = 1;
    end
    chk("busy_after_done", 32'(busy_o), 32'(m_run));
  endtask

  always @(negedge clk_i) begin
    if (bus.r_valid) begin
      if (sb.size() == 0) chk("unexpected_r_valid", 32'd1, 32'd0);
      else begin
        got = sb.pop_front();
        chk("r_data", bus.r_data, got.d);
        chk("r_id", 32'(bus.r_id), 32'(got.id));
      end
    end else chk("r_data_idle", bus.r_data, 32'd0);
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 0; done_i = 0;
    bus.req = 0; bus.wen = 0; bus.add = '0; bus.be = '0; bus.data = '0; bus.id = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    bus.req = 1; bus.wen = 1;
    #1;
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_r_valid", 32'(bus.r_valid), 32'd0);
    chk("reset_r_id", 32'(bus.r_id), 32'd0);
    chk("reset_start", 32'(start_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk_cfg("reset_cfg");
    bus.req = 0;
    rst_ni = 1;
    @(posedge clk_i); #1;

    do_write(32'd76, 4'hF, 32'h0000_1000);
    do_read(32'd76);
    do_write(32'd8, 4'hF, 32'h1122_3344);
    do_write(32'd8, 4'b0010, 32'hAABB_CCDD);
    do_read(32'd8);
    do_write(32'd0, 4'hF, 32'd1);
    pulse_done();
    do_read(32'd4);
    do_read(32'd4);
    do_write(32'd0, 4'hF, 32'd1);
    do_write(32'd40, 4'hF, 32'hDEAD_BEEF);
    do_read(32'd4);
    do_read(32'd40);
    do_write(32'd0, 4'hF, 32'd1);
    do_read(32'd4);
    pulse_done();
    pulse_done();
    do_write(32'd0, 4'hF, 32'd1);
    pulse_done();
    do_read(32'd400);
    do_write(32'd400, 4'hF, 32'h5555_5555);
    do_read(32'd0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int op;
      op = $urandom_range(0, 9);
      a = {30'($urandom_range(0, NCFG + 5)), 2'($urandom_range(0, 3))};
      if (op < 4) do_write(a, 4'($urandom), $urandom);
      else if (op < 7) do_read(a);
      else if (op == 7) pulse_done();
      else if (op == 8) do_write(32'd0, 4'hF, 32'd1);
      else do_read(32'd4);
    end

    if (!m_run) do_write(32'd0, 4'hF, 32'd1);
    begin
      bit ok;
      int w;
      bus.req = 1; bus.wen = 1; bus.add = 32'd76; bus.id = 5'd9;
      wait_gnt(ok, w);
      rst_ni = 0;
      #1;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_r_valid", 32'(bus.r_valid), 32'd0);
      chk("rst_r_data", bus.r_data, 32'd0);
      chk("rst_r_id", 32'(bus.r_id), 32'd0);
      chk("rst_start", 32'(start_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      bus.req = 0;
      model_reset();
      chk_cfg("rst_cfg");
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1;
      repeat (3) @(posedge clk_i);
      #1;
    end
    do_read(32'd4);
    do_read(32'd76);
    do_read(32'd400);

    repeat (3) @(posedge clk_i);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
